// File: rtl/pdp8_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pdp8_pkg
// Brief   : Shared types and constants for the PDP-8 fetch/decode front end.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package pdp8_pkg;

   typedef enum logic [2:0] {
      FETCH    = 3'd0,
      FWAIT    = 3'd1,
      IND_REQ  = 3'd2,
      IND_WAIT = 3'd3,
      AUTOINC  = 3'd4,
      OUT      = 3'd5
   } fd_state_t;

   typedef enum logic [2:0] {
      OP_AND = 3'd0,
      OP_TAD = 3'd1,
      OP_ISZ = 3'd2,
      OP_DCA = 3'd3,
      OP_JMS = 3'd4,
      OP_JMP = 3'd5,
      OP_IOT = 3'd6,
      OP_OPR = 3'd7
   } opcode_t;

   localparam logic [11:0] AUTOINDEX_LO = 12'o10;
   localparam logic [11:0] AUTOINDEX_HI = 12'o17;

   // AND..JMP address memory; IOT and OPR carry no operand address.
   function automatic logic is_mem_ref(input logic [2:0] op);
      return (op <= OP_JMP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pdp8_instr_fetch_decode_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pdp8_instr_fetch_decode_if
// Brief   : Instruction-memory bus plus decode handshake toward execute.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface pdp8_instr_fetch_decode_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 12
);
   logic                  ifu_rd_req;
   logic [ADDR_WIDTH-1:0] ifu_rd_addr;
   logic [DATA_WIDTH-1:0] ifu_rd_data;
   logic                  ifu_wr_req;
   logic [ADDR_WIDTH-1:0] ifu_wr_addr;
   logic [DATA_WIDTH-1:0] ifu_wr_data;
   logic                  dec_valid;
   logic                  dec_ready;
   logic [ADDR_WIDTH-1:0] dec_pc;
   logic [DATA_WIDTH-1:0] dec_ir;
   logic [2:0]            dec_opcode;
   logic                  dec_mem_ref;
   logic [ADDR_WIDTH-1:0] dec_ea;

   modport master (
      output ifu_rd_req, ifu_rd_addr,
      input  ifu_rd_data,
      output ifu_wr_req, ifu_wr_addr, ifu_wr_data,
      output dec_valid,
      input  dec_ready,
      output dec_pc, dec_ir, dec_opcode, dec_mem_ref, dec_ea
   );

   modport slave (
      input  ifu_rd_req, ifu_rd_addr,
      output ifu_rd_data,
      input  ifu_wr_req, ifu_wr_addr, ifu_wr_data,
      input  dec_valid,
      output dec_ready,
      input  dec_pc, dec_ir, dec_opcode, dec_mem_ref, dec_ea
   );
endinterface
`default_nettype wire

// File: rtl/pdp8_ea_calc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pdp8_ea_calc
// Brief   : Direct effective address (page 0 or current page) and autoindex flag.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module pdp8_ea_calc
   import pdp8_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 12
) (
   input  wire logic [DATA_WIDTH-1:0] i_ir,
   input  wire logic [ADDR_WIDTH-1:0] i_pc,
   output logic      [ADDR_WIDTH-1:0] o_ea,
   output logic                       o_autoidx
);
   logic [ADDR_WIDTH-1:0] w_page_base;
   logic                  w_unused_bits;

   assign w_page_base = i_ir[7] ? {i_pc[ADDR_WIDTH-1:7], 7'b0} : '0;
   assign o_ea        = w_page_base | ADDR_WIDTH'(i_ir[6:0]);
   assign o_autoidx   = (o_ea >= ADDR_WIDTH'(AUTOINDEX_LO)) &&
                        (o_ea <= ADDR_WIDTH'(AUTOINDEX_HI));

   assign w_unused_bits = ^{i_ir[DATA_WIDTH-1:8], i_pc[6:0]};
endmodule
`default_nettype wire

// File: rtl/pdp8_instr_fetch_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pdp8_instr_fetch_decode
// Brief   : PDP-8 fetch/decode with one-level indirection; ADDR_AUTOINC_EN adds
//           autoindex pre-increment through locations 0o10..0o17.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module pdp8_instr_fetch_decode
   import pdp8_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 12,
   parameter logic [ADDR_WIDTH-1:0] PC_RESET   = 12'o200
) (
   input  wire logic                  clk,
   input  wire logic                  reset_n,
   input  wire logic                  stall,
   input  wire logic                  pc_load,
   input  wire logic [ADDR_WIDTH-1:0] pc_load_value,
   pdp8_instr_fetch_decode_if.master  bus
);
   fd_state_t             r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
   logic [DATA_WIDTH-1:0] r_ir, w_ir_nxt;
   logic [ADDR_WIDTH-1:0] r_ea, w_ea_nxt;

   logic [DATA_WIDTH-1:0] w_ir_src;
   logic [ADDR_WIDTH-1:0] w_calc_ea;
   logic                  w_autoidx;
   logic                  w_rd_req, w_wr_req;
   logic [ADDR_WIDTH-1:0] w_rd_addr, w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic                  w_out;

   // While the word is arriving, decode straight from the bus; afterwards from IR.
   assign w_ir_src = (r_state == FWAIT) ? bus.ifu_rd_data : r_ir;

   pdp8_ea_calc #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ea_calc (
      .i_ir      (w_ir_src),
      .i_pc      (r_pc),
      .o_ea      (w_calc_ea),
      .o_autoidx (w_autoidx)
   );

`ifndef ADDR_AUTOINC_EN
   logic w_unused_autoidx;
   assign w_unused_autoidx = w_autoidx;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= FETCH;
         r_pc    <= PC_RESET;
         r_ir    <= '0;
         r_ea    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
         r_ea    <= w_ea_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_ea_nxt    = r_ea;
      w_rd_req    = 1'b0;
      w_rd_addr   = '0;
      w_wr_req    = 1'b0;
      w_wr_addr   = '0;
      w_wr_data   = '0;
      case (r_state)
         FETCH: begin
            w_rd_req  = !stall;
            w_rd_addr = r_pc;
            if (!stall) w_state_nxt = FWAIT;
         end
         FWAIT: begin
            w_ir_nxt = bus.ifu_rd_data;
            if (is_mem_ref(bus.ifu_rd_data[11:9])) begin
               w_ea_nxt    = w_calc_ea;
               w_state_nxt = bus.ifu_rd_data[8] ? IND_REQ : OUT;
            end else begin
               w_ea_nxt    = '0;
               w_state_nxt = OUT;
            end
         end
         IND_REQ: begin
            w_rd_req  = !stall;
            w_rd_addr = r_ea;
            if (!stall) w_state_nxt = IND_WAIT;
         end
         IND_WAIT: begin
            w_ea_nxt    = ADDR_WIDTH'(bus.ifu_rd_data);
            w_state_nxt = OUT;
`ifdef ADDR_AUTOINC_EN
            if (w_autoidx) begin
               w_ea_nxt    = ADDR_WIDTH'(bus.ifu_rd_data) + ADDR_WIDTH'(1);
               w_state_nxt = AUTOINC;
            end
`endif
         end
         AUTOINC: begin
`ifdef ADDR_AUTOINC_EN
            // IR still points at the pointer word; EA already holds pointer+1.
            w_wr_req  = 1'b1;
            w_wr_addr = w_calc_ea;
            w_wr_data = DATA_WIDTH'(r_ea);
`endif
            w_state_nxt = OUT;
         end
         OUT: begin
            if (bus.dec_ready) begin
               w_pc_nxt    = r_pc + ADDR_WIDTH'(1);
               w_state_nxt = FETCH;
            end
         end
         default: w_state_nxt = FETCH;
      endcase
      if (pc_load) begin
         w_pc_nxt    = pc_load_value;
         w_state_nxt = FETCH;
      end
   end

   assign w_out = reset_n && (r_state == OUT);

   assign bus.ifu_rd_req  = reset_n && w_rd_req;
   assign bus.ifu_rd_addr = reset_n ? w_rd_addr : '0;
   assign bus.ifu_wr_req  = reset_n && w_wr_req;
   assign bus.ifu_wr_addr = reset_n ? w_wr_addr : '0;
   assign bus.ifu_wr_data = reset_n ? w_wr_data : '0;

   assign bus.dec_valid   = w_out;
   assign bus.dec_pc      = w_out ? r_pc : '0;
   assign bus.dec_ir      = w_out ? r_ir : '0;
   assign bus.dec_opcode  = w_out ? r_ir[11:9] : 3'b0;
   assign bus.dec_mem_ref = w_out && is_mem_ref(r_ir[11:9]);
   assign bus.dec_ea      = w_out ? r_ea : '0;
endmodule
`default_nettype wire

// File: tb/tb_pdp8_instr_fetch_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_pdp8_instr_fetch_decode
// Brief   : Vector table, corner sequences and randomized run against a model.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pdp8_instr_fetch_decode;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0;
   logic        pc_load = 1'b0;
   logic [11:0] pc_load_value = 12'o0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] mem   [0:4095];
   logic [11:0] m_mem [0:4095];
   logic [23:0] wq[$];

   pdp8_instr_fetch_decode_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) bus();

   pdp8_instr_fetch_decode dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall         (stall),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.ifu_rd_req) bus.ifu_rd_data <= mem[bus.ifu_rd_addr];

   typedef struct {
      logic [11:0] pc, instr, ptr_addr, ptr_data;
      bit          ptr_used;
      logic [2:0]  op;
      bit          mref;
      logic [11:0] ea;
      int          lat, reads;
      bit          wr;
      logic [11:0] wa, wd;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(logic [11:0] pc, logic [11:0] instr, bit pu, logic [11:0] pa,
                               logic [11:0] pd, logic [2:0] op, bit mref, logic [11:0] ea,
                               int lat, int reads, bit wr, logic [11:0] wa, logic [11:0] wd);
      vec_t v;
      v.pc = pc; v.instr = instr; v.ptr_used = pu; v.ptr_addr = pa; v.ptr_data = pd;
      v.op = op; v.mref = mref; v.ea = ea; v.lat = lat; v.reads = reads;
      v.wr = wr; v.wa = wa; v.wd = wd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0o expected %0o", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired, event never seen", name);
   endtask

   task automatic check_all_zero(input string name);
      check(name, {bus.ifu_rd_req, bus.ifu_rd_addr, bus.ifu_wr_req, bus.ifu_wr_addr,
                   bus.ifu_wr_data}, 32'd0);
      check({name, "_dec"}, {bus.dec_valid, bus.dec_pc, bus.dec_opcode, bus.dec_mem_ref,
                             bus.dec_ea}, 32'd0);
      check({name, "_ir"}, bus.dec_ir, 32'd0);
   endtask

   task automatic redirect(input logic [11:0] pc);
      @(negedge clk); pc_load = 1'b1; pc_load_value = pc; stall = 1'b0; dec_ready_set(1'b1);
      @(negedge clk); pc_load = 1'b0; #1;
   endtask

   task automatic dec_ready_set(input logic r);
      bus.dec_ready = r;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      int reads;
      bit wr_seen;
      logic [11:0] wa, wd;
      string tag;
      tag = $sformatf("v%0d", idx);
      mem[v.pc] = v.instr;
      if (v.ptr_used) mem[v.ptr_addr] = v.ptr_data;
      redirect(v.pc);
      check({tag, "_req"}, {bus.ifu_rd_req, bus.ifu_rd_addr}, {1'b1, v.pc});
      lat = -1; reads = 0; wr_seen = 0; wa = 0; wd = 0;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         if (bus.ifu_rd_req) reads++;
         if (bus.ifu_wr_req) begin
            wr_seen = 1; wa = bus.ifu_wr_addr; wd = bus.ifu_wr_data; mem[wa] = wd;
         end
         if (bus.dec_valid) begin
            lat = k;
            check({tag, "_pc"}, bus.dec_pc, v.pc);
            check({tag, "_ir"}, bus.dec_ir, v.instr);
            check({tag, "_op"}, bus.dec_opcode, v.op);
            check({tag, "_mref"}, bus.dec_mem_ref, v.mref);
            check({tag, "_ea"}, bus.dec_ea, v.ea);
         end
      end
      if (lat < 0) fail_bound({tag, "_valid"});
      else begin
         check({tag, "_lat"}, lat, v.lat);
         check({tag, "_reads"}, reads, v.reads);
         check({tag, "_wr"}, {wr_seen, wa, wd}, v.wr ? {1'b1, v.wa, v.wd} : 25'd0);
         @(negedge clk); #1;
         check({tag, "_next"}, {bus.ifu_rd_req, bus.ifu_rd_addr}, {1'b1, v.pc + 12'd1});
      end
   endtask

   task automatic wait_req_addr(input logic [11:0] a, output bit found);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (bus.ifu_rd_req && bus.ifu_rd_addr == a) found = 1;
         else begin @(negedge clk); #1; end
      end
   endtask

   // Reference decode from memory contents; applies the autoindex write to m_mem.
   task automatic model_decode(input logic [11:0] pc, output logic [2:0] op, output bit mref,
                               output logic [11:0] ea, output bit wr, output logic [23:0] wentry);
      int ir, ptr, pval;
      ir = m_mem[pc];
      op = 3'(ir / 512);
      mref = (op < 6);
      ea = 0; wr = 0; wentry = 0;
      if (mref) begin
         ptr = ir % 128;
         if ((ir / 128) % 2 == 1) ptr = ptr + (pc - pc % 128);
         if ((ir / 256) % 2 == 1) begin
            pval = m_mem[ptr];
`ifdef ADDR_AUTOINC_EN
            if (ptr >= 8 && ptr <= 15) begin
               pval = (pval + 1) % 4096;
               m_mem[ptr] = 12'(pval);
               wr = 1;
               wentry = {12'(ptr), 12'(pval)};
            end
`endif
            ea = 12'(pval);
         end else ea = 12'(ptr);
      end
   endtask

   task automatic rand_test();
      logic [11:0] mpc, exp_ir, exp_ea, w;
      logic [2:0]  exp_op;
      bit          exp_mref, exp_wr, v, checked;
      logic [23:0] exp_w;
      int          n_rand;
      reset_n = 1'b0; stall = 1'b0; pc_load = 1'b0; bus.dec_ready = 1'b0;
      for (int a = 0; a < 4096; a++) begin
         if ($urandom_range(0, 3) == 0)
            w = 12'($urandom_range(0, 5) * 512 + 256 + 8 + $urandom_range(0, 7));
         else
            w = 12'($urandom);
         mem[a] = w; m_mem[a] = w;
      end
      wq.delete();
      @(negedge clk); @(negedge clk); reset_n = 1'b1;
      mpc = 12'o200; checked = 0; n_rand = 0;
      for (int cyc = 0; cyc < 8000 && n_rand < 150; cyc++) begin
         @(negedge clk);
         v = bus.dec_valid;
         stall = ($urandom_range(0, 3) == 0);
         bus.dec_ready = ($urandom_range(0, 2) != 0);
         pc_load = v && ($urandom_range(0, 9) == 0);
         pc_load_value = 12'($urandom);
         #1;
         if (bus.ifu_rd_req || bus.ifu_wr_req)
            check("rand_rd_wr_excl", bus.ifu_rd_req & bus.ifu_wr_req, 0);
         if (stall) check("rand_stall_noreq", bus.ifu_rd_req, 0);
         if (bus.ifu_wr_req) begin
            wq.push_back({bus.ifu_wr_addr, bus.ifu_wr_data});
            mem[bus.ifu_wr_addr] = bus.ifu_wr_data;
         end
         if (v) begin
            if (!checked) begin
               exp_ir = m_mem[mpc];
               model_decode(mpc, exp_op, exp_mref, exp_ea, exp_wr, exp_w);
               check("rand_pc", bus.dec_pc, mpc);
               check("rand_ir", bus.dec_ir, exp_ir);
               check("rand_op", bus.dec_opcode, exp_op);
               check("rand_mref", bus.dec_mem_ref, exp_mref);
               check("rand_ea", bus.dec_ea, exp_ea);
               check("rand_wr_cnt", wq.size(), exp_wr ? 1 : 0);
               if (exp_wr && wq.size() == 1) check("rand_wr_data", wq[0], exp_w);
               wq.delete();
               checked = 1;
               n_rand++;
            end
            if (pc_load) begin mpc = pc_load_value; checked = 0; end
            else if (bus.dec_ready) begin mpc = mpc + 12'd1; checked = 0; end
         end
      end
      if (n_rand < 150) fail_bound("rand_progress");
      pc_load = 1'b0; stall = 1'b0;
   endtask

   initial begin
      bit found;
      int k;
      bus.dec_ready = 1'b0;
      bus.ifu_rd_data = 12'o0;
      for (int a = 0; a < 4096; a++) begin mem[a] = 12'o0; m_mem[a] = 12'o0; end

`ifdef ADDR_AUTOINC_EN
      vecs[1] = mk(12'o200, 12'o5410, 1, 12'o10, 12'o0777, 5, 1, 12'o1000, 5, 2, 1, 12'o10, 12'o1000);
      vecs[5] = mk(12'o200, 12'o0417, 1, 12'o17, 12'o7777, 0, 1, 12'o0000, 5, 2, 1, 12'o17, 12'o0000);
`else
      vecs[1] = mk(12'o200, 12'o5410, 1, 12'o10, 12'o0777, 5, 1, 12'o0777, 4, 2, 0, 0, 0);
      vecs[5] = mk(12'o200, 12'o0417, 1, 12'o17, 12'o7777, 0, 1, 12'o7777, 4, 2, 0, 0, 0);
`endif
      vecs[0] = mk(12'o200,  12'o1205, 0, 0, 0,              1, 1, 12'o0205, 2, 1, 0, 0, 0);
      vecs[2] = mk(12'o200,  12'o7200, 0, 0, 0,              7, 0, 12'o0000, 2, 1, 0, 0, 0);
      vecs[3] = mk(12'o3456, 12'o2325, 0, 0, 0,              2, 1, 12'o3525, 2, 1, 0, 0, 0);
      vecs[4] = mk(12'o1000, 12'o4650, 1, 12'o1050, 12'o6543, 4, 1, 12'o6543, 4, 2, 0, 0, 0);
      vecs[6] = mk(12'o200,  12'o3420, 1, 12'o20, 12'o1234,  3, 1, 12'o1234, 4, 2, 0, 0, 0);
      vecs[7] = mk(12'o200,  12'o3407, 1, 12'o07, 12'o0055,  3, 1, 12'o0055, 4, 2, 0, 0, 0);
      vecs[8] = mk(12'o200,  12'o6777, 0, 0, 0,              6, 0, 12'o0000, 2, 1, 0, 0, 0);
      vecs[9] = mk(12'o7777, 12'o5177, 0, 0, 0,              5, 1, 12'o0177, 2, 1, 0, 0, 0);

      // Reset state and first fetch address.
      repeat (3) @(negedge clk);
      #1 check_all_zero("reset");
      @(negedge clk); reset_n = 1'b1; #1;
      check("reset_first_req", {bus.ifu_rd_req, bus.ifu_rd_addr}, {1'b1, 12'o200});

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Stall during FETCH, then execute back-pressure.
      mem[12'o200] = 12'o1205;
      @(negedge clk); pc_load = 1'b1; pc_load_value = 12'o200; stall = 1'b1; bus.dec_ready = 1'b0;
      @(negedge clk); pc_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1 check($sformatf("stall_noreq%0d", i), bus.ifu_rd_req, 0);
      end
      @(negedge clk); stall = 1'b0; #1;
      check("stall_release_req", {bus.ifu_rd_req, bus.ifu_rd_addr}, {1'b1, 12'o200});
      found = 0;
      for (k = 0; k < 10 && !found; k++) begin
         @(negedge clk); #1;
         if (bus.dec_valid) found = 1;
      end
      if (!found) fail_bound("bp_valid");
      else begin
         check("bp_lat", k, 2);
         for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            check($sformatf("bp_hold%0d", i),
                  {bus.dec_valid, bus.ifu_rd_req, bus.dec_pc, bus.dec_ea},
                  {1'b1, 1'b0, 12'o200, 12'o205});
            check($sformatf("bp_ir%0d", i), bus.dec_ir, 12'o1205);
         end
         @(negedge clk); bus.dec_ready = 1'b1;
         @(negedge clk); #1;
         check("bp_next_req", {bus.ifu_rd_req, bus.ifu_rd_addr}, {1'b1, 12'o201});
      end

      // pc_load while the indirect word is in flight.
      mem[12'o200] = 12'o1450; mem[12'o50] = 12'o3333;
      mem[12'o7777] = 12'o7000; mem[12'o0] = 12'o7000;
      redirect(12'o200);
      wait_req_addr(12'o50, found);
      if (!found) fail_bound("pcl_ind_req");
      else begin
         @(negedge clk); pc_load = 1'b1; pc_load_value = 12'o7777; #1;
         check("pcl_no_valid_iw", bus.dec_valid, 0);
         @(negedge clk); pc_load = 1'b0; #1;
         check("pcl_new_req", {bus.dec_valid, bus.ifu_rd_req, bus.ifu_rd_addr}, {2'b01, 12'o7777});
         found = 0;
         for (k = 0; k < 10 && !found; k++) begin
            @(negedge clk); #1;
            if (bus.dec_valid) found = 1;
         end
         if (!found) fail_bound("pcl_valid");
         else begin
            check("pcl_dec", {bus.dec_pc, bus.dec_opcode, bus.dec_mem_ref}, {12'o7777, 3'd7, 1'b0});
            @(negedge clk); #1;
            check("pcl_wrap_req", {bus.ifu_rd_req, bus.ifu_rd_addr}, {1'b1, 12'o0000});
         end
      end

      // Reset in the middle of the indirect request.
      redirect(12'o200);
      wait_req_addr(12'o50, found);
      if (!found) fail_bound("rst_ind_req");
      else begin
         #2 reset_n = 1'b0;
         #1 check_all_zero("rst_mid");
         @(negedge clk); #1 check_all_zero("rst_hold");
         @(negedge clk); reset_n = 1'b1; #1;
         check("rst_next_req", {bus.ifu_rd_req, bus.ifu_rd_addr}, {1'b1, 12'o200});
      end

      rand_test();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
